unidade_controle: RTL

//  Multicycle control unit that drives the datapath: instruction memory, register bank, adder, Mux1, Mux2, data memory.

---
 rtl/ctrl_pkg.sv | 40 ++++
 rtl/ctrl_decoder.sv | 42 ++++
 rtl/unidade_controle.sv | 110 +++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle control unit: FSM state codes,
// instruction encodings and the select/ALU codes driven to the datapath.
package ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE   = 4'd0;
  localparam state_t S_FETCH  = 4'd1;
  localparam state_t S_LATCH  = 4'd2;
  localparam state_t S_DECODE = 4'd3;
  localparam state_t S_EXEC   = 4'd4;
  localparam state_t S_MEM    = 4'd5;
  localparam state_t S_WB     = 4'd6;
  localparam state_t S_DONE   = 4'd7;
  localparam state_t S_ERROR  = 4'd8;

  typedef enum logic [1:0] {
    CLS_ARITH = 2'd0,
    CLS_LOAD  = 2'd1,
    CLS_STORE = 2'd2
  } instr_cls_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_ARITHI = 7'b0010011;

  localparam logic [6:0] F7_ADD  = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_SUBI = 3'b010;

  localparam logic ALU_ADD  = 1'b0;
  localparam logic ALU_SUB  = 1'b1;
  localparam logic MUX1_IMM = 1'b0;
  localparam logic MUX1_RB  = 1'b1;
  localparam logic MUX2_MEM = 1'b0;
  localparam logic MUX2_ALU = 1'b1;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational instruction decoder: classifies the latched instruction and
// produces the ALU/mux selects; flags anything outside the supported set.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output instr_cls_e cls,
  output logic       alu_sinal,
  output logic       mux1_sel,
  output logic       mux2_sel,
  output logic       illegal
);

  always_comb begin
    cls       = CLS_ARITH;
    alu_sinal = ALU_ADD;
    mux1_sel  = MUX1_IMM;
    mux2_sel  = MUX2_ALU;
    illegal   = 1'b0;
    case (opcode)
      // memory ops compute rs1 + imm on the adder
      OP_LOAD: begin
        cls      = CLS_LOAD;
        mux2_sel = MUX2_MEM;
      end
      OP_STORE: cls = CLS_STORE;
      OP_ARITH: begin
        mux1_sel = MUX1_RB;
        if (funct7 == F7_SUB)      alu_sinal = ALU_SUB;
        else if (funct7 != F7_ADD) illegal   = 1'b1;
      end
      OP_ARITHI: begin
        if (funct3 == F3_SUBI)      alu_sinal = ALU_SUB;
        else if (funct3 != F3_ADDI) illegal   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control unit: fetch/latch/decode FSM sequencing the datapath.
// Optional retire counter enabled by UNIDADE_CONTROLE_RETIRE_CNT_EN.
module unidade_controle
  import ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(1),
  parameter logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(6)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [63:0]       imem_dout,
  output logic [ADDR_W-1:0] imem_ads,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] rf_ra,
  output logic [ADDR_W-1:0] rf_rb,
  output logic [ADDR_W-1:0] rf_rw,
  output logic              rf_we,
  output logic              alu_sinal,
  output logic              mux1_sel,
  output logic              mux2_sel,
  output logic              dmem_we,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef UNIDADE_CONTROLE_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  instr_cls_e        dec_cls;
  logic              dec_alu, dec_m1, dec_m2, dec_illegal;
  logic              active, retire, start_ok;
  logic              unused_imem_hi;

  assign unused_imem_hi = ^imem_dout[63:32];

  ctrl_decoder u_dec (
    .opcode   (instr[6:0]),
    .funct3   (instr[14:12]),
    .funct7   (instr[31:25]),
    .cls      (dec_cls),
    .alu_sinal(dec_alu),
    .mux1_sel (dec_m1),
    .mux2_sel (dec_m2),
    .illegal  (dec_illegal)
  );

  assign start_ok = start && (state == S_IDLE || state == S_DONE);
  assign retire   = (state == S_WB) || (state == S_EXEC && dec_cls == CLS_STORE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= PC_RESET;
      instr <= '0;
    end else if (start_ok) begin
      state <= S_FETCH;
      pc    <= PC_RESET;
    end else if (retire) begin
      if (pc == PC_LAST) state <= S_DONE;
      else begin
        pc    <= pc + ADDR_W'(1);
        state <= S_FETCH;
      end
    end else begin
      case (state)
        S_FETCH:  state <= S_LATCH;
        S_LATCH: begin
          instr <= imem_dout[31:0];
          state <= S_DECODE;
        end
        S_DECODE: state <= dec_illegal ? S_ERROR : S_EXEC;
        S_EXEC:   state <= (dec_cls == CLS_LOAD) ? S_MEM : S_WB;
        S_MEM:    state <= S_WB;
        default:  ;
      endcase
    end
  end

  // selects/addresses only drive the datapath from DECODE until retire
  assign active = state inside {S_DECODE, S_EXEC, S_MEM, S_WB};

  assign imem_ads  = pc;
  assign rf_ra     = active ? ADDR_W'(instr[19:15]) : '0;
  assign rf_rb     = !active ? '0 :
                     (dec_cls == CLS_STORE) ? ADDR_W'(instr[11:7]) : ADDR_W'(instr[24:20]);
  assign rf_rw     = (active && dec_cls != CLS_STORE) ? ADDR_W'(instr[11:7]) : '0;
  assign alu_sinal = active & dec_alu;
  assign mux1_sel  = active & dec_m1;
  assign mux2_sel  = active & dec_m2;
  assign rf_we     = (state == S_WB);
  assign dmem_we   = (state == S_EXEC) && (dec_cls == CLS_STORE);
  assign busy      = state inside {S_FETCH, S_LATCH, S_DECODE, S_EXEC, S_MEM, S_WB};
  assign done      = (state == S_DONE);
  assign err       = (state == S_ERROR);

`ifdef UNIDADE_CONTROLE_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               retire_cnt <= '0;
    else if (start_ok)                        retire_cnt <= '0;
    else if (retire && retire_cnt != '1)      retire_cnt <= retire_cnt + 32'd1;
  end
`endif

endmodule
